nb_sdram_bridge: RTL and testbench

//  Decoupling stage between northbridge (386SX bus-cycle master) and the 16-bit SDRAM controller.

---
 rtl/nb_sdram_pkg.sv | 23 ++
 rtl/nb_sdram_fifo.sv | 68 ++++++
 rtl/nb_sdram_bridge.sv | 246 ++++++++++++++++++++++++
 tb/tb_nb_sdram_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nb_sdram_pkg.sv
// Shared types for the northbridge-to-SDRAM bridge: command layout,
// field offsets and issue FSM state encoding.
package nb_sdram_pkg;

    localparam int CMD_W        = 41;
    localparam int CMD_DATA_LSB = 0;
    localparam int CMD_BE_LSB   = 16;
    localparam int CMD_ADDR_LSB = 18;
    localparam int CMD_WR_BIT   = 40;

    typedef struct packed {
        logic        is_wr;
        logic [21:0] addr;
        logic [1:0]  be_n;
        logic [15:0] data;
    } cmd_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/nb_sdram_fifo.sv
// Single-clock show-ahead command FIFO.
// Ports: i_push/i_wdata write side; i_pop advances the head;
//   o_head is the oldest entry, o_next the one behind it;
//   o_full/o_empty/o_count report occupancy.
module nb_sdram_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [WIDTH-1:0]         o_next,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW-1:0]    w_rd_ptr_nx;

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_count     = r_count;
    assign w_push_ok   = i_push && !o_full;
    assign w_pop_ok    = i_pop && !o_empty;
    assign w_rd_ptr_nx = r_rd_ptr + AW'(1);
    assign o_head      = r_mem[r_rd_ptr];
    assign o_next      = r_mem[w_rd_ptr_nx];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= w_rd_ptr_nx;
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nb_sdram_bridge.sv
// Decoupling bridge between the 386SX northbridge and the SDRAM controller.
// Ports: up_* northbridge side (requests, waitrequest, in-order read
//   data with up_valid pulse); az_* commands to the controller, held
//   under za_waitrequest; za_* read returns; err sticky protocol flag;
//   stat_* 16-bit wrapping counters.
// Build option: NB_SDRAM_BRIDGE_STATS_EN enables the stat_* counters,
//   otherwise they are tied to zero.
module nb_sdram_bridge
    import nb_sdram_pkg::*;
#(
    parameter int CMD_DEPTH  = 4,
    parameter int MAX_RD_OUT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [21:0] up_addr,
    input  logic [1:0]  up_be_n,
    input  logic [15:0] up_wdata,
    input  logic        up_rd_n,
    input  logic        up_wr_n,
    output logic        up_waitrequest,
    output logic [15:0] up_rdata,
    output logic        up_valid,
    output logic [21:0] az_addr,
    output logic [1:0]  az_be_n,
    output logic [15:0] az_data,
    output logic        az_rd_n,
    output logic        az_wr_n,
    input  logic [15:0] za_data,
    input  logic        za_valid,
    input  logic        za_waitrequest,
    output logic        err,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_stall
);

    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(MAX_RD_OUT) + 1;
    localparam int TW = ((CW > RW) ? CW : RW) + 1;
    localparam logic [TW-1:0] LP_MAX_T = TW'(MAX_RD_OUT);
    localparam logic [RW-1:0] LP_MAX_R = RW'(MAX_RD_OUT);

    logic             w_rd_req;
    logic             w_wr_req;
    logic             w_both;
    logic             w_rd_block;
    logic             w_waitreq;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    cmd_t             w_push_cmd;
    logic [CMD_W-1:0] w_head;
    logic [CMD_W-1:0] w_next;
    logic [CMD_W-1:0] w_ld;
    logic             w_done;
    logic             w_done_rd;
    logic             w_ret;
    logic             w_credit;
    logic             w_issue_idle;
    logic             w_issue_b2b;
    logic [RW-1:0]    w_rd_out_nx;
    logic [TW-1:0]    w_rd_total;

    state_t           r_state;
    logic [21:0]      r_az_addr;
    logic [1:0]       r_az_be_n;
    logic [15:0]      r_az_data;
    logic             r_az_rd_n;
    logic             r_az_wr_n;
    logic [RW-1:0]    r_rd_out;
    logic [CW-1:0]    r_q_rd;
    logic             r_up_valid;
    logic [15:0]      r_up_rdata;
    logic             r_err;

    assign w_rd_req = !up_rd_n && up_wr_n;
    assign w_wr_req = up_rd_n && !up_wr_n;
    assign w_both   = !up_rd_n && !up_wr_n;

    // Reads still queued (including the one on az_*) plus reads awaiting
    // data must never exceed the credit limit.
    assign w_rd_total = TW'(r_q_rd) + TW'(r_rd_out);
    assign w_rd_block = w_rd_req && (w_rd_total >= LP_MAX_T);
    assign w_waitreq  = !reset_n || w_full || w_both || w_rd_block;
    assign w_push     = (w_rd_req || w_wr_req) && !w_waitreq;

    assign w_push_cmd = '{is_wr: w_wr_req,
                          addr:  up_addr,
                          be_n:  up_be_n,
                          data:  up_wdata};

    // The head entry stays in the FIFO until the controller takes it,
    // so the command on az_* still occupies a slot.
    nb_sdram_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_wdata (w_push_cmd),
        .i_pop   (w_done),
        .o_head  (w_head),
        .o_next  (w_next),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_done    = (r_state == ST_ISSUE) && !za_waitrequest;
    assign w_done_rd = w_done && !r_az_rd_n;
    assign w_ret     = za_valid && (r_rd_out != '0);

    always_comb begin
        w_rd_out_nx = r_rd_out;
        unique case ({w_done_rd, w_ret})
            2'b10:   w_rd_out_nx = r_rd_out + RW'(1);
            2'b01:   w_rd_out_nx = r_rd_out - RW'(1);
            default: w_rd_out_nx = r_rd_out;
        endcase
    end

    // A read may go out only if its eventual completion still fits.
    assign w_credit = (w_rd_out_nx < LP_MAX_R);

    assign w_issue_idle = (r_state == ST_IDLE) && !w_empty
                        && (w_head[CMD_WR_BIT] || w_credit);
    assign w_issue_b2b  = w_done && (w_count >= CW'(2))
                        && (w_next[CMD_WR_BIT] || w_credit);

    assign w_ld = (r_state == ST_ISSUE) ? w_next : w_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_az_addr <= '0;
            r_az_be_n <= '0;
            r_az_data <= '0;
            r_az_rd_n <= 1'b1;
            r_az_wr_n <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_issue_idle) begin
                        r_az_addr <= w_ld[CMD_ADDR_LSB +: 22];
                        r_az_be_n <= w_ld[CMD_BE_LSB +: 2];
                        r_az_data <= w_ld[CMD_DATA_LSB +: 16];
                        r_az_wr_n <= !w_ld[CMD_WR_BIT];
                        r_az_rd_n <= w_ld[CMD_WR_BIT];
                        r_state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_issue_b2b) begin
                        r_az_addr <= w_ld[CMD_ADDR_LSB +: 22];
                        r_az_be_n <= w_ld[CMD_BE_LSB +: 2];
                        r_az_data <= w_ld[CMD_DATA_LSB +: 16];
                        r_az_wr_n <= !w_ld[CMD_WR_BIT];
                        r_az_rd_n <= w_ld[CMD_WR_BIT];
                    end else if (w_done) begin
                        r_az_rd_n <= 1'b1;
                        r_az_wr_n <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_out <= '0;
            r_q_rd   <= '0;
        end else begin
            r_rd_out <= w_rd_out_nx;
            unique case ({w_push && w_rd_req, w_done_rd})
                2'b10:   r_q_rd <= r_q_rd + CW'(1);
                2'b01:   r_q_rd <= r_q_rd - CW'(1);
                default: r_q_rd <= r_q_rd;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_up_valid <= 1'b0;
            r_up_rdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_up_valid <= w_ret;
            if (w_ret) begin
                r_up_rdata <= za_data;
            end
            // Conflicting request or data with no read outstanding.
            if (w_both || (za_valid && (r_rd_out == '0))) begin
                r_err <= 1'b1;
            end
        end
    end

`ifdef NB_SDRAM_BRIDGE_STATS_EN
    logic [15:0] r_stat_rd;
    logic [15:0] r_stat_wr;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_rd    <= '0;
            r_stat_wr    <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_ret) begin
                r_stat_rd <= r_stat_rd + 16'd1;
            end
            if (w_done && !r_az_wr_n) begin
                r_stat_wr <= r_stat_wr + 16'd1;
            end
            if ((!up_rd_n || !up_wr_n) && w_waitreq) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_rd    = r_stat_rd;
    assign stat_wr    = r_stat_wr;
    assign stat_stall = r_stat_stall;
`else
    assign stat_rd    = '0;
    assign stat_wr    = '0;
    assign stat_stall = '0;
`endif

    assign up_waitrequest = w_waitreq;
    assign up_rdata       = r_up_rdata;
    assign up_valid       = r_up_valid;
    assign az_addr        = r_az_addr;
    assign az_be_n        = r_az_be_n;
    assign az_data        = r_az_data;
    assign az_rd_n        = r_az_rd_n;
    assign az_wr_n        = r_az_wr_n;
    assign err            = r_err;

endmodule

// File: tb/tb_nb_sdram_bridge.sv
// Directed bench for nb_sdram_bridge with a command/read scoreboard
// and a simple SDRAM controller responder.
module tb_nb_sdram_bridge;

    logic        clk;
    logic        reset_n;
    logic [21:0] up_addr;
    logic [1:0]  up_be_n;
    logic [15:0] up_wdata;
    logic        up_rd_n;
    logic        up_wr_n;
    logic        up_waitrequest;
    logic [15:0] up_rdata;
    logic        up_valid;
    logic [21:0] az_addr;
    logic [1:0]  az_be_n;
    logic [15:0] az_data;
    logic        az_rd_n;
    logic        az_wr_n;
    logic [15:0] za_data;
    logic        za_valid;
    logic        za_waitrequest;
    logic        err;
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_stall;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          due;
        logic [15:0] d;
    } pend_t;

    logic [40:0] exp_cmd [$];
    logic [15:0] exp_rd  [$];
    pend_t       pend    [$];
    logic [15:0] ref_mem [logic [21:0]];
    logic [15:0] ctl_mem [logic [21:0]];

    int          cyc      = 0;
    int          tb_rd_out = 0;
    int          wr_done  = 0;
    int          rd_done  = 0;
    logic        exp_uv   = 1'b0;
    logic        hold     = 1'b0;
    logic        za_wait  = 1'b0;
    logic        resp_v   = 1'b0;
    logic [15:0] resp_d   = '0;
    logic        inj_v    = 1'b0;
    logic [15:0] inj_d    = '0;
    logic [40:0] c_pop;
    logic        ok;

    assign za_waitrequest = za_wait;
    assign za_valid       = resp_v | inj_v;
    assign za_data        = resp_v ? resp_d : inj_d;

    nb_sdram_bridge dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .up_addr        (up_addr),
        .up_be_n        (up_be_n),
        .up_wdata       (up_wdata),
        .up_rd_n        (up_rd_n),
        .up_wr_n        (up_wr_n),
        .up_waitrequest (up_waitrequest),
        .up_rdata       (up_rdata),
        .up_valid       (up_valid),
        .az_addr        (az_addr),
        .az_be_n        (az_be_n),
        .az_data        (az_data),
        .az_rd_n        (az_rd_n),
        .az_wr_n        (az_wr_n),
        .za_data        (za_data),
        .za_valid       (za_valid),
        .za_waitrequest (za_waitrequest),
        .err            (err),
        .stat_rd        (stat_rd),
        .stat_wr        (stat_wr),
        .stat_stall     (stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    // Scoreboard checks plus controller responder.
    always @(posedge clk) begin
        logic ret;
        logic hs;
        if (!reset_n) begin
            exp_cmd.delete();
            exp_rd.delete();
            pend.delete();
            tb_rd_out = 0;
            exp_uv    = 1'b0;
            wr_done   = 0;
            rd_done   = 0;
        end else begin
            check("up_valid", up_valid, exp_uv);
            if (up_valid) begin
                rd_done++;
                check("rd_sb_nonempty", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0)
                    check("up_rdata", up_rdata, exp_rd.pop_front());
            end
            ret    = za_valid && (tb_rd_out != 0);
            exp_uv = ret;
            if (ret) tb_rd_out--;
            hs = (!az_rd_n || !az_wr_n) && !za_waitrequest;
            if (hs) begin
                check("cmd_sb_nonempty", exp_cmd.size() != 0, 1);
                if (exp_cmd.size() != 0) begin
                    c_pop = exp_cmd.pop_front();
                    check("az_cmd",
                          {!az_wr_n, az_addr, az_be_n,
                           az_wr_n ? 16'h0 : az_data}, c_pop);
                end
                if (!az_wr_n) begin
                    ctl_mem[az_addr] = az_data;
                    wr_done++;
                end else begin
                    pend.push_back('{due: cyc + 2,
                        d: ctl_mem.exists(az_addr) ?
                           ctl_mem[az_addr] : 16'h0});
                    tb_rd_out++;
                end
            end
        end
        cyc++;
        #1;
        if (reset_n && !hold && pend.size() != 0 && cyc >= pend[0].due) begin
            resp_v = 1'b1;
            resp_d = pend[0].d;
            void'(pend.pop_front());
        end else begin
            resp_v = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one request for up to maxw cycles; entered and left at posedge+1.
    task automatic do_req(input logic wr, input logic [21:0] a,
                          input logic [1:0] be, input logic [15:0] d,
                          input int maxw, output logic acc);
        up_addr  = a;
        up_be_n  = be;
        up_wdata = d;
        up_wr_n  = !wr;
        up_rd_n  = wr;
        acc      = 1'b0;
        for (int i = 0; i < maxw && !acc; i++) begin
            @(negedge clk);
            if (!up_waitrequest) begin
                acc = 1'b1;
                exp_cmd.push_back({wr, a, be, wr ? d : 16'h0});
                if (wr) ref_mem[a] = d;
                else exp_rd.push_back(ref_mem.exists(a) ? ref_mem[a] : 16'h0);
            end
            tick();
        end
        up_wr_n = 1'b1;
        up_rd_n = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (exp_cmd.size() == 0 && exp_rd.size() == 0 &&
                pend.size() == 0 && !up_valid && az_rd_n && az_wr_n)
                break;
            tick();
        end
        tick();
        check("drain", exp_cmd.size() + exp_rd.size() + pend.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        up_addr  = '0;
        up_be_n  = '0;
        up_wdata = '0;
        up_rd_n  = 1'b1;
        up_wr_n  = 1'b1;
        tick();
        check("rst_waitreq", up_waitrequest, 1);
        check("rst_az_n", {az_rd_n, az_wr_n}, 2'b11);
        check("rst_az_bus", {az_addr, az_be_n, az_data}, 0);
        check("rst_up", {up_valid, up_rdata, err}, 0);
        check("rst_stats", {stat_rd, stat_wr, stat_stall}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_waitreq", up_waitrequest, 0);

        // 1: single posted write
        do_req(1'b1, 22'h10, 2'b00, 16'h1234, 4, ok);
        check("t1_accept", ok, 1);
        check("t1_not_yet", az_wr_n, 1);
        tick();
        check("t1_az_wr_n", az_wr_n, 0);
        check("t1_az_addr", az_addr, 22'h10);
        check("t1_az_data", az_data, 16'h1234);
        wait_idle();
        check("t1_fifo_empty", dut.w_empty, 1);

        // 2: read back the same address
        do_req(1'b0, 22'h10, 2'b00, 16'h0, 4, ok);
        check("t2_accept", ok, 1);
        wait_idle();

        // 3: controller stalled, five writes offered
        za_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b1, 22'h20 + 22'(i), 2'(i), 16'hA000 + 16'(i), 2, ok);
            check("t3_accept", ok, 1);
        end
        do_req(1'b1, 22'h24, 2'b00, 16'hA004, 1, ok);
        check("t3_fifth_blocked", ok, 0);
        for (int i = 0; i < 14; i++) begin
            check("t3_hold_wr_n", az_wr_n, 0);
            check("t3_hold_addr", az_addr, 22'h20);
            check("t3_hold_data", az_data, 16'hA000);
            tick();
        end
        za_wait = 1'b0;
        do_req(1'b1, 22'h24, 2'b00, 16'hA004, 10, ok);
        check("t3_fifth_accept", ok, 1);
        wait_idle();
`ifdef NB_SDRAM_BRIDGE_STATS_EN
        check("t3_stall_cnt", stat_stall != 0, 1);
`endif

        // 4: read credit exhaustion
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 22'h20 + 22'(i), 2'b00, 16'h0, 4, ok);
            check("t4_accept", ok, 1);
        end
        up_addr = 22'h24;
        up_rd_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t4_blocked", up_waitrequest, 1);
            tick();
        end
        hold = 1'b0;
        do_req(1'b0, 22'h24, 2'b00, 16'h0, 20, ok);
        check("t4_fifth_accept", ok, 1);
        wait_idle();

        // 5: spurious read data
        check("t5_err_before", err, 0);
        inj_d = 16'hDEAD;
        inj_v = 1'b1;
        tick();
        inj_v = 1'b0;
        check("t5_err_set", err, 1);
        check("t5_rd_out", dut.r_rd_out, 0);
        repeat (3) tick();
        check("t5_err_sticky", err, 1);
`ifdef NB_SDRAM_BRIDGE_STATS_EN
        check("t5_stat_wr", stat_wr, 16'(wr_done));
        check("t5_stat_rd", stat_rd, 16'(rd_done));
`else
        check("t5_stat_off", {stat_rd, stat_wr, stat_stall}, 0);
`endif

        // 6: reset with reads outstanding
        hold = 1'b1;
        do_req(1'b0, 22'h20, 2'b00, 16'h0, 4, ok);
        check("t6_accept_a", ok, 1);
        do_req(1'b0, 22'h21, 2'b00, 16'h0, 4, ok);
        check("t6_accept_b", ok, 1);
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        check("t6_rst_waitreq", up_waitrequest, 1);
        check("t6_rst_az_n", {az_rd_n, az_wr_n}, 2'b11);
        check("t6_rst_az_bus", {az_addr, az_be_n, az_data}, 0);
        check("t6_rst_up", {up_valid, up_rdata, err}, 0);
        check("t6_rst_stat_rd", stat_rd, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold    = 1'b0;
        tick();
        check("t6_post_waitreq", up_waitrequest, 0);
        check("t6_post_err", err, 0);
        do_req(1'b0, 22'h10, 2'b00, 16'h0, 4, ok);
        check("t6_accept_c", ok, 1);
        wait_idle();
`ifdef NB_SDRAM_BRIDGE_STATS_EN
        check("t6_stat_rd", stat_rd, 16'(rd_done));
`endif
        check("t6_rd_seen", rd_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
